wheel_speed_sequencer: RTL and testbench

Controller that drives one wheel encoder datapath (quadrature decoder plus 8-bit pulse counter) through fixed measurement windows. Each window clears the counter, gates it for GATE_CYCLES clocks, captures the count and classifies it into a 2-bit speed level with a direction code. It sits between the wheel encoder interface and the game logic of Cyclone Cruiser, and is the only block that clears the wheel counter.

---
 rtl/wheel_speed_sequencer_pkg.sv | 44 ++++
 rtl/wheel_speed_sequencer_gate_timer.sv | 29 ++
 rtl/wheel_speed_sequencer.sv | 109 ++++++++++
 tb/tb_wheel_speed_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wheel_speed_sequencer_pkg.sv
// Shared types and constants for the wheel speed measurement sequencer.
// Includes the count-to-speed classifier used when a window is evaluated.
package wheel_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GATE,
        CAPTURE,
        EVAL
    } state_t;

    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_CW   = 2'b01;
    localparam logic [1:0] DIR_CCW  = 2'b10;
    localparam logic [1:0] DIR_REV  = 2'b11;

    localparam logic [1:0] SPEED_0 = 2'd0;
    localparam logic [1:0] SPEED_1 = 2'd1;
    localparam logic [1:0] SPEED_2 = 2'd2;
    localparam logic [1:0] SPEED_3 = 2'd3;

    localparam logic [7:0] COUNT_MAX = 8'd255;

    // A count equal to a threshold belongs to the higher level.
    function automatic logic [1:0] classify(
        input logic [7:0] count,
        input logic [7:0] t1,
        input logic [7:0] t2,
        input logic [7:0] t3
    );
        logic [1:0] level;
        level = SPEED_0;
        if (count >= t3) begin
            level = SPEED_3;
        end else if (count >= t2) begin
            level = SPEED_2;
        end else if (count >= t1) begin
            level = SPEED_1;
        end
        return level;
    endfunction

endpackage

// File: rtl/wheel_speed_sequencer_gate_timer.sv
// Loadable down-counter timing the counting window; holds at zero until
// the next load so a stalled controller never sees a wrapped count.
module gate_timer #(
    parameter int GATE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int WIDTH = $clog2(GATE_CYCLES);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= WIDTH'(GATE_CYCLES - 1);
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/wheel_speed_sequencer.sv
// Runs fixed measurement windows on the wheel encoder counter: clear, gate,
// capture, then publish a speed level, direction code and saturation flag.
module wheel_speed_sequencer
    import wheel_pkg::*;
#(
    parameter int GATE_CYCLES = 50000,
    parameter int T1          = 4,
    parameter int T2          = 16,
    parameter int T3          = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] count_in,
    input  logic       cw_in,
    input  logic       ccw_in,
    output logic       clear_count,
    output logic [1:0] speed_level,
    output logic [1:0] direction,
    output logic       overflow,
    output logic       sample_valid,
    output logic       busy
);

    state_t state_reg;
    logic   cw_seen_reg;
    logic   ccw_seen_reg;
    logic   gate_zero;
    logic   timer_load;
    logic   timer_dec;

    assign timer_load = (state_reg == CLEAR);
    assign timer_dec  = (state_reg == GATE);

    gate_timer #(
        .GATE_CYCLES(GATE_CYCLES)
    ) u_gate_timer (
        .clk  (clk),
        .reset(reset),
        .load (timer_load),
        .dec  (timer_dec),
        .zero (gate_zero)
    );

    // Outputs are registered: each is set on the edge that enters the state
    // in which it must be visible, so clear_count and sample_valid line up
    // exactly with the CLEAR and EVAL cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            cw_seen_reg  <= 1'b0;
            ccw_seen_reg <= 1'b0;
            clear_count  <= 1'b0;
            speed_level  <= SPEED_0;
            direction    <= DIR_NONE;
            overflow     <= 1'b0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            clear_count  <= 1'b0;
            sample_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (enable) begin
                        state_reg   <= CLEAR;
                        clear_count <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                CLEAR: begin
                    state_reg    <= GATE;
                    cw_seen_reg  <= 1'b0;
                    ccw_seen_reg <= 1'b0;
                end
                GATE: begin
                    cw_seen_reg  <= cw_seen_reg | cw_in;
                    ccw_seen_reg <= ccw_seen_reg | ccw_in;
                    if (gate_zero) begin
                        state_reg <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // The snapshot lands straight in the held output registers.
                    state_reg    <= EVAL;
                    cw_seen_reg  <= cw_seen_reg | cw_in;
                    ccw_seen_reg <= ccw_seen_reg | ccw_in;
                    speed_level  <= classify(count_in, 8'(T1), 8'(T2), 8'(T3));
                    direction    <= {ccw_seen_reg | ccw_in, cw_seen_reg | cw_in};
                    overflow     <= (count_in == COUNT_MAX);
                    sample_valid <= 1'b1;
                end
                EVAL: begin
                    if (enable) begin
                        state_reg   <= CLEAR;
                        clear_count <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wheel_speed_sequencer.sv
// Randomised scoreboard bench for wheel_speed_sequencer: stimulus pushes the
// expected window result, a negedge monitor pops and compares on sample_valid.
module tb_wheel_speed_sequencer;

    localparam int GC = 10;
    localparam int T1 = 4;
    localparam int T2 = 16;
    localparam int T3 = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] count_in;
    logic       cw_in;
    logic       ccw_in;
    logic       clear_count;
    logic [1:0] speed_level;
    logic [1:0] direction;
    logic       overflow;
    logic       sample_valid;
    logic       busy;

    always #5 clk = ~clk;

    wheel_speed_sequencer #(
        .GATE_CYCLES(GC),
        .T1         (T1),
        .T2         (T2),
        .T3         (T3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .count_in    (count_in),
        .cw_in       (cw_in),
        .ccw_in      (ccw_in),
        .clear_count (clear_count),
        .speed_level (speed_level),
        .direction   (direction),
        .overflow    (overflow),
        .sample_valid(sample_valid),
        .busy        (busy)
    );

    typedef struct {
        logic [1:0] speed;
        logic [1:0] dir;
        logic       ovf;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] hold_speed = 2'd0;
    logic [1:0] hold_dir   = 2'd0;
    logic       hold_ovf   = 1'b0;
    int         cyc        = 0;
    int         last_clear = -1000;
    int         last_sv    = -1000;

    function automatic logic [1:0] ref_level(input int c);
        if (c >= T3) return 2'd3;
        if (c >= T2) return 2'd2;
        if (c >= T1) return 2'd1;
        return 2'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: timing of strobes and scoreboard comparison on sample_valid.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (reset === 1'b1) begin
            if (clear_count) begin
                if (last_sv == cyc - 1) check("clear_period", cyc - last_clear, GC + 3);
                last_clear = cyc;
            end
            if (sample_valid) begin
                check("clear_to_valid", cyc - last_clear, GC + 2);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: sample_valid with no pending window (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("speed_level", speed_level, e.speed);
                    check("direction", direction, e.dir);
                    check("overflow", overflow, e.ovf);
                    $display("window @%0d: speed=%0d dir=%0d ovf=%0d (exp %0d/%0d/%0d)",
                             cyc, speed_level, direction, overflow, e.speed, e.dir, e.ovf);
                    hold_speed = e.speed;
                    hold_dir   = e.dir;
                    hold_ovf   = e.ovf;
                end
                last_sv = cyc;
            end
        end else begin
            last_clear = -1000;
            last_sv    = -1000;
            hold_speed = 2'd0;
            hold_dir   = 2'd0;
            hold_ovf   = 1'b0;
        end
    end

    // One full window. Returns at the negedge inside the EVAL cycle.
    task automatic run_window(input logic [7:0] cnt, input logic [GC-1:0] cwm, input logic [GC-1:0] ccwm,
                              input logic cap_cw, input logic cap_ccw,
                              input logic clr_cw, input logic clr_ccw, input int drop_at);
        int   waited;
        exp_t e;
        waited = 0;
        while (waited == 0 || (!clear_count && waited < 40)) begin
            @(negedge clk);
            waited++;
        end
        check("clear_latency", waited, 1);
        if (!clear_count) return;
        cw_in    = clr_cw;
        ccw_in   = clr_ccw;
        count_in = 8'($urandom);
        for (int i = 0; i < GC; i++) begin
            @(negedge clk);
            if (i == 0) check("busy_in_gate", busy, 1);
            cw_in    = cwm[i];
            ccw_in   = ccwm[i];
            count_in = 8'($urandom);
            if (i == drop_at) enable = 1'b0;
        end
        @(negedge clk);
        count_in = cnt;
        cw_in    = cap_cw;
        ccw_in   = cap_ccw;
        e.speed  = ref_level(int'(cnt));
        e.dir    = {(|ccwm) | cap_ccw, (|cwm) | cap_cw};
        e.ovf    = (cnt == 8'd255);
        exp_q.push_back(e);
        @(negedge clk);
        cw_in    = 1'b0;
        ccw_in   = 1'b0;
        count_in = 8'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] boundary_tbl [9];
        logic [7:0] cnt;
        logic [GC-1:0] cwm, ccwm;
        boundary_tbl = '{8'd0, 8'd3, 8'd4, 8'd15, 8'd16, 8'd63, 8'd64, 8'd254, 8'd255};

        reset    = 1'b0;
        enable   = 1'b1;
        count_in = 8'd0;
        cw_in    = 1'b0;
        ccw_in   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_clear_count", clear_count, 0);
        check("rst_speed", speed_level, 0);
        check("rst_direction", direction, 0);
        check("rst_overflow", overflow, 0);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;

        run_window(8'd20, {GC{1'b1}}, '0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        run_window(8'd3, '0, 10'b0100100010, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        run_window(8'd4, '0, 10'b0000000001, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        run_window(8'd255, 10'b0000010000, 10'b0000010000, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        run_window(8'd64, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0, -1);

        for (int w = 0; w < 16; w++) begin
            if ($urandom_range(1) == 0) cnt = boundary_tbl[$urandom_range(8)];
            else cnt = 8'($urandom);
            cwm  = GC'($urandom & $urandom & $urandom);
            ccwm = GC'($urandom & $urandom & $urandom);
            run_window(cnt, cwm, ccwm, 1'($urandom_range(3) == 0), 1'($urandom_range(3) == 0),
                       1'b0, 1'b0, -1);
        end

        // Enable dropped mid-gate: the window completes, then the FSM idles.
        run_window(8'd17, 10'b0000000100, '0, 1'b0, 1'b0, 1'b0, 1'b0, 5);
        @(negedge clk);
        check("idle_busy", busy, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_no_clear", clear_count, 0);
        end
        check("hold_speed", speed_level, hold_speed);
        check("hold_direction", direction, hold_dir);
        check("hold_overflow", overflow, hold_ovf);
        check("idle_busy_late", busy, 0);

        // Reset in the middle of GATE: no result, everything back to zero.
        enable = 1'b1;
        @(negedge clk);
        check("restart_clear", clear_count, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cw_in    = 1'b1;
            count_in = 8'd200;
        end
        reset = 1'b0;
        @(negedge clk);
        cw_in = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_speed", speed_level, 0);
        check("midrst_direction", direction, 0);
        check("midrst_overflow", overflow, 0);
        check("midrst_sample_valid", sample_valid, 0);
        enable = 1'b0;
        reset  = 1'b1;
        for (int i = 0; i < GC + 6; i++) begin
            @(negedge clk);
            check("midrst_no_valid", sample_valid, 0);
        end

        // Direction pulses during CLEAR must be ignored.
        enable = 1'b1;
        run_window(8'd30, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        for (int w = 0; w < 4; w++) begin
            cnt = 8'($urandom);
            run_window(cnt, GC'($urandom & $urandom), GC'($urandom & $urandom), 1'b0, 1'b0,
                       1'b1, 1'b0, (w == 3) ? 2 : -1);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("final_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
